// File: rtl/timer_counter_pkg.sv
// Shared definitions for the timer/counter peripheral: bus window, register
// offsets, CTRL bit positions and FSM state encoding.
package timer_counter_pkg;

  localparam logic [15:0] TC_BASE_ADDR = 16'h7f00;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  localparam logic [1:0] MODE_RELOAD = 2'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } tc_state_e;

  // Only encoding 1 reloads; 0, 2 and 3 all behave as one-shot.
  function automatic logic is_reload(input logic [3:0] ctrl);
    return ctrl[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD;
  endfunction

endpackage

// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer with one-shot and auto-reload modes;
// raises irq when the count expires and the interrupt is unmasked.
module timer_counter
  import timer_counter_pkg::*;
#(
  parameter int COUNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  logic [3:0]         ctrl;
  logic [COUNT_W-1:0] preset;
  logic [COUNT_W-1:0] count;
  logic               irq_flag;
  tc_state_e          state;

  logic ctrl_wr;
  logic preset_wr;
  logic unused_addr;

  assign ctrl_wr     = we && (addr[1:0] == REG_CTRL);
  assign preset_wr   = we && (addr[1:0] == REG_PRESET);
  assign unused_addr = ^addr[29:2];

  assign irq = irq_flag & ctrl[CTRL_IM];

  // Register file, interrupt flag and count-down sequencer.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl     <= 4'd0;
      preset   <= '0;
      count    <= '0;
      irq_flag <= 1'b0;
      state    <= ST_IDLE;
    end else begin
      if (preset_wr) begin
        preset <= din[COUNT_W-1:0];
      end

      // A CPU write to CTRL overrides the one-shot self-disable.
      if (ctrl_wr) begin
        ctrl <= din[3:0];
      end else if ((state == ST_INT) && !is_reload(ctrl)) begin
        ctrl[CTRL_EN] <= 1'b0;
      end

      if (state == ST_INT) begin
        irq_flag <= 1'b1;
      end else if (ctrl_wr) begin
        irq_flag <= 1'b0;
      end else if ((state == ST_IDLE) && ctrl[CTRL_EN] && is_reload(ctrl)) begin
        irq_flag <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (ctrl[CTRL_EN]) begin
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          count <= preset;
          state <= ST_CNT;
        end
        ST_CNT: begin
          if (!ctrl[CTRL_EN]) begin
            state <= ST_IDLE;
          end else if (count > COUNT_W'(1)) begin
            count <= count - COUNT_W'(1);
          end else begin
            count <= '0;
            state <= ST_INT;
          end
        end
        ST_INT: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Read mux; unmapped offset and CTRL upper bits read as zero.
  always_comb begin
    dout = 32'd0;
    case (addr[1:0])
      REG_CTRL:   dout = {28'd0, ctrl};
      REG_PRESET: dout = 32'(preset);
      REG_COUNT:  dout = 32'(count);
      default:    dout = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: directed scenarios with literal
// expectations plus randomized bus traffic against a run-age timeline model.
module tb_timer_counter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        we = 1'b0;
  logic [29:0] addr = 30'd0;
  logic [31:0] din = 32'd0;
  logic [31:0] dout;
  logic        irq;

  int tests = 0;
  int fails = 0;
  logic chk_en = 1'b0;

  timer_counter #(.COUNT_W(32)) dut (
    .clk(clk), .reset(reset), .addr(addr), .we(we),
    .din(din), .dout(dout), .irq(irq)
  );

  always #5 clk = ~clk;

  // Model: a run is tracked by its age in edges since enable was noticed
  // (age 0 = preset being captured, -1 = not running).
  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic        flag;
    longint      age;
    logic [31:0] n;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t mstep(mstate_t s, logic rst, logic w,
                                    logic [1:0] a, logic [31:0] d);
    mstate_t r;
    logic    en, reload, at_int;
    longint  e_age;
    r = s;
    if (rst) begin
      r.ctrl = 4'd0; r.preset = 32'd0; r.count = 32'd0;
      r.flag = 1'b0; r.age = -1; r.n = 32'd0;
      return r;
    end
    en     = s.ctrl[0];
    reload = (s.ctrl[2:1] == 2'd1);
    e_age  = (s.n == 32'd0) ? 64'sd2 : longint'(s.n) + 64'sd1;
    at_int = (s.age >= 1) && (s.age == e_age);
    if (w && a == 2'd0) r.ctrl = d[3:0];
    else if (at_int && !reload) r.ctrl[0] = 1'b0;
    if (w && a == 2'd1) r.preset = d;
    if (at_int) r.flag = 1'b1;
    else if (w && a == 2'd0) r.flag = 1'b0;
    else if (s.age < 0 && en && reload) r.flag = 1'b0;
    if (s.age < 0) begin
      if (en) r.age = 0;
    end else if (s.age == 0) begin
      r.age = 1; r.n = s.preset; r.count = s.preset;
    end else if (at_int || !en) begin
      r.age = -1;
    end else begin
      r.age = s.age + 1;
      r.count = (longint'(s.n) > r.age - 1) ? 32'(longint'(s.n) - (r.age - 1)) : 32'd0;
    end
    return r;
  endfunction

  function automatic logic [31:0] mread(mstate_t s, logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, s.ctrl};
      2'd1:    return s.preset;
      2'd2:    return s.count;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) m <= mstep(m, reset, we, addr[1:0], din);

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_dout", dout, mread(m, addr[1:0]));
      check("model_irq", {31'd0, irq}, {31'd0, m.flag & m.ctrl[3]});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(logic [1:0] a, logic [31:0] d);
    addr = {28'd0, a}; din = d; we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  task automatic rd(string nm, logic [1:0] a, logic [31:0] exp);
    addr = {28'd0, a};
    #1;
    check(nm, dout, exp);
  endtask

  task automatic do_reset();
    reset = 1'b1; we = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  logic [31:0] rv;
  int r;

  initial begin
    do_reset();
    chk_en = 1'b1;

    // Reset values and read-only COUNT
    rd("rst_ctrl", 2'd0, 32'd0);
    rd("rst_preset", 2'd1, 32'd0);
    rd("rst_count", 2'd2, 32'd0);
    rd("rst_reg3", 2'd3, 32'd0);
    tick();
    wr(2'd2, 32'h55);
    rd("count_ro", 2'd2, 32'd0);
    tick();

    // One-shot with interrupt enabled
    do_reset();
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    addr = 30'd2;
    tick(); tick();
    check("m0_cnt_e2", dout, 32'd5);
    repeat (4) tick();
    check("m0_cnt_e6", dout, 32'd1);
    tick();
    check("m0_cnt_e7", dout, 32'd0);
    check("m0_irq_e7", {31'd0, irq}, 32'd0);
    tick();
    check("m0_irq_e8", {31'd0, irq}, 32'd1);
    rd("m0_ctrl", 2'd0, 32'h8);
    tick();
    check("m0_irq_hold", {31'd0, irq}, 32'd1);
    wr(2'd0, 32'h8);
    check("m0_irq_clr", {31'd0, irq}, 32'd0);

    // Auto-reload: pulse every N+3 cycles
    do_reset();
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    addr = 30'd2;
    for (int e = 1; e <= 24; e++) begin
      tick();
      check("m1_irq", {31'd0, irq}, {31'd0, (e % 6) == 0});
      if ((e % 6) == 2) check("m1_reload", dout, 32'd3);
    end

    // Masked interrupt, cleared by the unmasking write
    do_reset();
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h1);
    for (int e = 1; e <= 6; e++) begin
      tick();
      check("im0_irq", {31'd0, irq}, 32'd0);
    end
    rd("im0_ctrl", 2'd0, 32'd0);
    wr(2'd0, 32'h8);
    check("im0_unmask", {31'd0, irq}, 32'd0);
    tick();
    check("im0_unmask2", {31'd0, irq}, 32'd0);

    // PRESET change mid-count, abort, re-enable
    do_reset();
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h1);
    addr = 30'd2;
    repeat (4) tick();
    wr(2'd1, 32'd2);
    rd("ab_cnt7", 2'd2, 32'd7);
    tick();
    check("ab_cnt6", dout, 32'd6);
    tick();
    check("ab_cnt5", dout, 32'd5);
    wr(2'd0, 32'h0);
    rd("ab_cnt4", 2'd2, 32'd4);
    repeat (3) tick();
    check("ab_frozen", dout, 32'd4);
    check("ab_noirq", {31'd0, irq}, 32'd0);
    wr(2'd0, 32'h9);
    addr = 30'd2;
    tick(); tick();
    check("ab_reload", dout, 32'd2);
    tick(); tick();
    check("ab_irq_e4", {31'd0, irq}, 32'd0);
    check("ab_cnt0", dout, 32'd0);
    tick();
    check("ab_irq_e5", {31'd0, irq}, 32'd1);

    // PRESET=0 one-shot
    do_reset();
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    repeat (3) tick();
    check("p0_irq_e3", {31'd0, irq}, 32'd0);
    tick();
    check("p0_irq_e4", {31'd0, irq}, 32'd1);

    // Reset while counting
    do_reset();
    wr(2'd1, 32'd20);
    wr(2'd0, 32'h9);
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rc_irq", {31'd0, irq}, 32'd0);
    rd("rc_ctrl", 2'd0, 32'd0);
    rd("rc_preset", 2'd1, 32'd0);
    rd("rc_count", 2'd2, 32'd0);
    rd("rc_reg3", 2'd3, 32'd0);
    tick();

    // CTRL write landing on the INT edge
    do_reset();
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h9);
    repeat (4) tick();
    wr(2'd0, 32'hB);
    rd("sim_ctrl", 2'd0, 32'hB);
    check("sim_irq", {31'd0, irq}, 32'd1);
    tick();

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rv = $urandom;
      r = $urandom_range(0, 15);
      reset = ($urandom_range(0, 499) == 0);
      we = 1'b0;
      if (r < 2) begin
        we = 1'b1; addr = {rv[29:2], 2'd0};
        din = {rv[31:4], rv[3:1], rv[5] | rv[6]};
      end else if (r == 2) begin
        we = 1'b1; addr = {rv[29:2], 2'd1};
        din = rv[7] ? rv : 32'($urandom_range(0, 12));
      end else if (r == 3) begin
        we = 1'b1; addr = {rv[29:2], 1'b1, rv[0]};
        din = $urandom;
      end else begin
        addr = rv[29:0];
      end
      tick();
    end
    we = 1'b0; reset = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
